// File: rtl/coin_pkg.sv
// Shared types and constants for the coin manager: animation faces, scan states
// and the face-advance helper.
package coin_pkg;

  localparam int       COORD_W   = 10;
  localparam bit [7:0] COUNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    FACE_FRONT = 2'd0,
    FACE_SIDE  = 2'd1,
    FACE_BACK  = 2'd2
  } face_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Spin order is front -> side -> back -> front; encoding 3 is never produced.
  function automatic face_t next_face(input face_t f);
    case (f)
      FACE_FRONT: return FACE_SIDE;
      FACE_SIDE:  return FACE_BACK;
      default:    return FACE_FRONT;
    endcase
  endfunction

endpackage

// File: rtl/coin_manager_if.sv
// Bundle between the level logic (master) and the coin manager (slave), including
// the scan FSM state and index exposed for observation.
interface coin_manager_if #(
  parameter int NUM_COINS = 4
) ();
  import coin_pkg::*;

  // No valid/ready pair: frame_clk is a free-running level strobe; each 0->1
  // transition seen in the Clk domain starts one scan, positions are held by the
  // master while the scan runs, and coin_event is an unacknowledged 1-cycle pulse.
  logic                           frame_clk;
  logic [COORD_W-1:0]             process;
  logic [COORD_W-1:0]             player_x;
  logic [COORD_W-1:0]             player_y;
  logic [NUM_COINS*COORD_W-1:0]   coin_x_flat;
  logic [NUM_COINS*COORD_W-1:0]   coin_y_flat;
  logic [NUM_COINS-1:0]           coin_alive;
  face_t                          face;
  logic [7:0]                     coin_count;
  logic                           coin_event;
  scan_state_t                    scan_state;
  logic [3:0]                     scan_idx;

  modport master (
    output frame_clk, process, player_x, player_y, coin_x_flat, coin_y_flat,
    input  coin_alive, face, coin_count, coin_event, scan_state, scan_idx
  );

  modport slave (
    input  frame_clk, process, player_x, player_y, coin_x_flat, coin_y_flat,
    output coin_alive, face, coin_count, coin_event, scan_state, scan_idx
  );

endinterface

// File: rtl/coin_hit_cmp.sv
// Combinational player/coin hitbox overlap test in 11-bit unsigned arithmetic so
// that scrolled player positions past 1023 do not wrap.
module coin_hit_cmp #(
  parameter int COIN_W   = 16,
  parameter int COIN_H   = 28,
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 32
) (
  input  logic [9:0] player_x,
  input  logic [9:0] process,
  input  logic [9:0] player_y,
  input  logic [9:0] coin_x,
  input  logic [9:0] coin_y,
  output logic       hit
);

  logic [10:0] pxw;
  logic [10:0] px_r;
  logic [10:0] py_b;
  logic [10:0] cx_r;
  logic [10:0] cy_b;

  assign pxw  = {1'b0, player_x} + {1'b0, process};
  assign px_r = pxw + 11'(PLAYER_W);
  assign py_b = {1'b0, player_y} + 11'(PLAYER_H);
  assign cx_r = {1'b0, coin_x} + 11'(COIN_W);
  assign cy_b = {1'b0, coin_y} + 11'(COIN_H);

  // Strict compares: boxes that only share an edge are not touching.
  assign hit = (pxw < cx_r) && ({1'b0, coin_x} < px_r) &&
               ({1'b0, player_y} < cy_b) && ({1'b0, coin_y} < py_b);

endmodule

// File: rtl/coin_manager.sv
// Level-wide coin controller: shared spin face, once-per-frame sequential overlap
// scan over all coins, alive flags and a saturating collected-coin counter.
module coin_manager
  import coin_pkg::*;
#(
  parameter int NUM_COINS       = 4,
  parameter int FRAMES_PER_FACE = 4,
  parameter int COIN_W          = 16,
  parameter int COIN_H          = 28,
  parameter int PLAYER_W        = 16,
  parameter int PLAYER_H        = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  coin_manager_if.slave       bus
);

  localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COINS - 1);
  localparam logic [7:0]       TIMER_LAST = 8'(FRAMES_PER_FACE - 1);

  logic                 frame_q;
  logic                 edge_pulse;
  logic [7:0]           timer_q;
  face_t                face_q;
  scan_state_t          state_q, state_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic                 eval;
  logic                 hit;
  logic [NUM_COINS-1:0] alive_q;
  logic [7:0]           count_q;
  logic                 event_q;
  logic [COORD_W-1:0]   cx_arr [NUM_COINS];
  logic [COORD_W-1:0]   cy_arr [NUM_COINS];

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_unpack
    assign cx_arr[g] = bus.coin_x_flat[g*COORD_W +: COORD_W];
    assign cy_arr[g] = bus.coin_y_flat[g*COORD_W +: COORD_W];
  end

  coin_hit_cmp #(
    .COIN_W  (COIN_W),
    .COIN_H  (COIN_H),
    .PLAYER_W(PLAYER_W),
    .PLAYER_H(PLAYER_H)
  ) u_cmp (
    .player_x(bus.player_x),
    .process (bus.process),
    .player_y(bus.player_y),
    .coin_x  (cx_arr[idx_q]),
    .coin_y  (cy_arr[idx_q]),
    .hit     (hit)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q    <= 1'b0;
      edge_pulse <= 1'b0;
      timer_q    <= 8'd0;
      face_q     <= FACE_FRONT;
    end else begin
      frame_q    <= bus.frame_clk;
      edge_pulse <= bus.frame_clk & ~frame_q;
      if (edge_pulse) begin
        if (timer_q == TIMER_LAST) begin
          timer_q <= 8'd0;
          face_q  <= next_face(face_q);
        end else begin
          timer_q <= timer_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
    end
  end

  // A pulse arriving mid-scan is dropped: only IDLE listens for edges.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    eval    = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_pulse) begin
          state_n = SCAN;
          idx_n   = '0;
        end
      end
      SCAN: begin
        eval = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      alive_q <= '1;
      count_q <= 8'd0;
      event_q <= 1'b0;
    end else begin
      event_q <= 1'b0;
      if (eval && hit && alive_q[idx_q]) begin
        alive_q[idx_q] <= 1'b0;
        count_q        <= (count_q == COUNT_MAX) ? COUNT_MAX : count_q + 8'd1;
        event_q        <= 1'b1;
      end
    end
  end

  assign bus.coin_alive = alive_q;
  assign bus.face       = face_q;
  assign bus.coin_count = count_q;
  assign bus.coin_event = event_q;
  assign bus.scan_state = state_q;
  assign bus.scan_idx   = 4'(idx_q);

endmodule

// File: tb/tb_coin_manager.sv
// Bench for coin_manager: directed frame sequences plus randomized frames, checked
// against a frame-level model of faces, collections and the collected count.
module tb_coin_manager;
  import coin_pkg::*;

  localparam int NC  = 4;
  localparam int FPF = 4;
  localparam int CW  = 16;
  localparam int CH  = 28;
  localparam int PW  = 16;
  localparam int PH  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coin_manager_if #(.NUM_COINS(NC)) bus ();

  coin_manager #(
    .NUM_COINS(NC), .FRAMES_PER_FACE(FPF),
    .COIN_W(CW), .COIN_H(CH), .PLAYER_W(PW), .PLAYER_H(PH)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int px_m, pr_m, py_m;
  int cx_m [NC];
  int cy_m [NC];
  bit alive_m [NC];
  int count_m;
  int pulses_m;
  int exp_ev;
  int ev_cnt;
  logic [7:0] exp_q [$];

  logic [NC-1:0] alive_hist [10];
  bit            ev_hist [10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every event must match the next expected post-collection count.
  always @(negedge clk) begin
    if (bus.coin_event === 1'b1) begin
      ev_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'd1, 32'd0);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        check("event_count", 32'(bus.coin_count), 32'(e));
      end
    end
  end

  function automatic bit model_hit(input int i);
    int pxw;
    pxw = px_m + pr_m;
    return (pxw < cx_m[i] + CW) && (cx_m[i] < pxw + PW) &&
           (py_m < cy_m[i] + CH) && (cy_m[i] < py_m + PH);
  endfunction

  function automatic logic [NC-1:0] model_alive();
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = alive_m[i];
    return v;
  endfunction

  task automatic apply_inputs();
    bus.player_x = 10'(px_m);
    bus.process  = 10'(pr_m);
    bus.player_y = 10'(py_m);
    for (int i = 0; i < NC; i++) begin
      bus.coin_x_flat[i*10 +: 10] = 10'(cx_m[i]);
      bus.coin_y_flat[i*10 +: 10] = 10'(cy_m[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) alive_m[i] = 1'b1;
    count_m  = 0;
    pulses_m = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One frame: model predicts the whole scan, then the DUT runs it and is compared.
  task automatic do_frame();
    apply_inputs();
    exp_ev = 0;
    pulses_m++;
    for (int i = 0; i < NC; i++) begin
      if (alive_m[i] && model_hit(i)) begin
        alive_m[i] = 1'b0;
        count_m    = (count_m < 255) ? count_m + 1 : 255;
        exp_ev++;
        exp_q.push_back(8'(count_m));
      end
    end
    @(negedge clk);
    ev_cnt = 0;
    bus.frame_clk = 1'b1;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.frame_clk = 1'b0;
      alive_hist[k] = bus.coin_alive;
      ev_hist[k]    = bus.coin_event;
    end
    check("frame_alive", 32'(bus.coin_alive), 32'(model_alive()));
    check("frame_count", 32'(bus.coin_count), 32'(count_m));
    check("frame_events", 32'(ev_cnt), 32'(exp_ev));
    check("frame_face", 32'(bus.face), 32'((pulses_m / FPF) % 3));
    check("frame_idle", 32'(bus.scan_state), 32'(IDLE));
  endtask

  task automatic park_coins();
    for (int i = 0; i < NC; i++) begin
      cx_m[i] = 900;
      cy_m[i] = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.frame_clk = 1'b0;
    px_m = 0; pr_m = 0; py_m = 300;
    park_coins();
    apply_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_alive", 32'(bus.coin_alive), 32'hF);
    check("rst_face", 32'(bus.face), 32'(FACE_FRONT));
    check("rst_count", 32'(bus.coin_count), 32'd0);
    check("rst_event", 32'(bus.coin_event), 32'd0);
    check("rst_state", 32'(bus.scan_state), 32'(IDLE));

    // Face rotation over 13 frames with no coin in reach.
    for (int f = 0; f < 13; f++) do_frame();
    check("face_after_13", 32'(bus.face), 32'(FACE_FRONT));

    // Coin2 collected; exact result timing relative to the pulse.
    do_reset();
    px_m = 100; pr_m = 0; py_m = 300;
    cx_m[2] = 110; cy_m[2] = 300;
    do_frame();
    check("c2_alive_e3", 32'(alive_hist[4]), 32'hF);
    check("c2_alive_e4", 32'(alive_hist[5]), 32'hB);
    check("c2_ev_e3", 32'(ev_hist[4]), 32'd0);
    check("c2_ev_e4", 32'(ev_hist[5]), 32'd1);
    check("c2_ev_e5", 32'(ev_hist[6]), 32'd0);
    check("c2_count", 32'(bus.coin_count), 32'd1);
    for (int f = 0; f < 3; f++) do_frame();
    check("c2_count_held", 32'(bus.coin_count), 32'd1);

    // Scrolled player collects coin0; touching edges on coin1 do not count.
    px_m = 60; pr_m = 50;
    cx_m[0] = 110; cy_m[0] = 300;
    do_frame();
    check("c0_alive", 32'(bus.coin_alive), 32'hA);
    cx_m[0] = 900; cy_m[0] = 0;
    cx_m[1] = 110; cy_m[1] = 300;
    px_m = 94;  do_frame();
    px_m = 76;  do_frame();
    px_m = 10;  do_frame();
    check("c1_edges_alive", 32'(bus.coin_alive), 32'hA);
    px_m = 75;  do_frame();
    check("c1_inside_alive", 32'(bus.coin_alive), 32'h8);

    // Player world x beyond 1023 must not wrap onto a coin near x=0.
    do_reset();
    park_coins();
    px_m = 1000; pr_m = 60; py_m = 300;
    cx_m[3] = 30; cy_m[3] = 300;
    do_frame();
    check("wrap_alive", 32'(bus.coin_alive), 32'hF);

    // Reset while the scan sits on coin1.
    px_m = 100; pr_m = 0;
    park_coins();
    cx_m[0] = 110; cy_m[0] = 300;
    do_frame();
    cx_m[1] = 110; cy_m[1] = 300;
    apply_inputs();
    @(negedge clk);
    bus.frame_clk = 1'b1;
    @(negedge clk);
    bus.frame_clk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_state", 32'(bus.scan_state), 32'(SCAN));
    check("mid_idx", 32'(bus.scan_idx), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_alive", 32'(bus.coin_alive), 32'hF);
    check("mid_rst_count", 32'(bus.coin_count), 32'd0);
    check("mid_rst_face", 32'(bus.face), 32'(FACE_FRONT));
    check("mid_rst_event", 32'(bus.coin_event), 32'd0);
    check("mid_rst_state", 32'(bus.scan_state), 32'(IDLE));
    rst = 1'b0;
    model_reset();

    // Saturation: preload 254, then two collections in one frame.
    park_coins();
    @(negedge clk);
    force dut.count_q = 8'd254;
    @(negedge clk);
    release dut.count_q;
    count_m = 254;
    @(negedge clk);
    check("sat_preload", 32'(bus.coin_count), 32'd254);
    cx_m[0] = 110; cy_m[0] = 300;
    cx_m[1] = 105; cy_m[1] = 290;
    do_frame();
    check("sat_count", 32'(bus.coin_count), 32'd255);

    // Randomized frames.
    do_reset();
    for (int f = 0; f < 24; f++) begin
      if (f == 12) do_reset();
      px_m = $urandom_range(0, 300);
      pr_m = $urandom_range(0, 200);
      py_m = $urandom_range(250, 350);
      for (int i = 0; i < NC; i++) begin
        cx_m[i] = $urandom_range(0, 520);
        cy_m[i] = $urandom_range(240, 380);
      end
      do_frame();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
